// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and flow controller for the five-stage pipeline (IF, ID, EX, MEM, WB).
//  - Tracks in-flight register writers in EX and MEM with shadow tags.
//  - Stalls ID on read-after-write hazards.
//  - Kills wrong-path instructions when MEM redirects the PC.
//  - Keeps a saturating count of RAW stall cycles.
// Optional feature macro: HAZ_BR_STALL_EN
//  - Undefined (default): predict-not-taken; id_cti is ignored.
//  - Defined: after a branch/jump leaves ID, the front end waits in BR_EX and
//    BR_MEM until the branch resolves in MEM.
module pipe_hazard_ctrl #(
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr,
    input  logic [4:0]        id_dst,
    input  logic              id_cti,
    input  logic              mem_redirect,
    output logic              pc_hold,
    output logic              id_hold,
    output logic              id_kill,
    output logic              ex_kill,
    output logic [SCNT_W-1:0] stall_cnt,
    output logic              busy
);

    // Shadow tags of the register writers currently in EX and MEM
    logic [4:0]        ex_tag_reg;
    logic              ex_tv_reg;
    logic [4:0]        mem_tag_reg;
    logic              mem_tv_reg;
    logic [SCNT_W-1:0] stall_cnt_reg;

    // Per-source hazard detection: index 0 is rs, index 1 is rt
    logic [1:0][4:0] src_reg_sel;
    logic [1:0]      src_use;
    logic [1:0]      src_haz;
    logic            raw;

    assign src_reg_sel[0] = id_rs;
    assign src_reg_sel[1] = id_rt;
    assign src_use[0]     = id_use_rs;
    assign src_use[1]     = id_use_rt;

    // r0 is hard-wired to zero, so it never creates a dependency
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_haz[gi] = src_use[gi] && (src_reg_sel[gi] != 5'd0) &&
                                 ((ex_tv_reg  && (src_reg_sel[gi] == ex_tag_reg)) ||
                                  (mem_tv_reg && (src_reg_sel[gi] == mem_tag_reg)));
        end
    endgenerate

    assign raw = id_valid && (|src_haz);

    logic in_br;

`ifdef HAZ_BR_STALL_EN
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BR_EX  = 2'd1,
        BR_MEM = 2'd2
    } state_t;

    state_t state_reg;

    // Branch-wait FSM: a branch that leaves ID (no RAW, no redirect) blocks
    // fetch until it has resolved in MEM; a redirect ends the wait early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN:     if (!mem_redirect && !raw && id_valid && id_cti) state_reg <= BR_EX;
                BR_EX:   state_reg <= mem_redirect ? RUN : BR_MEM;
                default: state_reg <= RUN;
            endcase
        end
    end

    assign in_br = (state_reg != RUN);
`else
    logic unused_cti;
    assign unused_cti = id_cti;
    assign in_br      = 1'b0;
`endif

    logic raw_stall;
    logic br_wait;
    logic ex_enter;

    // Control outputs: redirect beats branch wait, branch wait beats RAW stall
    always_comb begin
        pc_hold   = 1'b0;
        id_hold   = 1'b0;
        id_kill   = 1'b0;
        ex_kill   = 1'b0;
        raw_stall = 1'b0;
        br_wait   = 1'b0;
        if (!rst) begin
            if (mem_redirect) begin
                id_kill = 1'b1;
                ex_kill = 1'b1;
            end else if (in_br) begin
                pc_hold = 1'b1;
                id_kill = 1'b1;
                br_wait = 1'b1;
            end else if (raw) begin
                pc_hold   = 1'b1;
                id_hold   = 1'b1;
                ex_kill   = 1'b1;
                raw_stall = 1'b1;
            end
        end
    end

    assign busy     = raw_stall || br_wait;
    assign ex_enter = id_valid && id_wr && (id_dst != 5'd0) && !ex_kill;

    // Tag pipeline: ID->EX, EX->MEM; a redirect stops the wrong-path EX writer
    // from becoming a MEM writer, and the MEM tag simply retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag_reg  <= 5'd0;
            ex_tv_reg   <= 1'b0;
            mem_tag_reg <= 5'd0;
            mem_tv_reg  <= 1'b0;
        end else begin
            mem_tag_reg <= ex_tag_reg;
            mem_tv_reg  <= ex_tv_reg && !mem_redirect;
            ex_tag_reg  <= id_dst;
            ex_tv_reg   <= ex_enter;
        end
    end

    // Saturating RAW-stall counter for the debug display
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (raw_stall && (stall_cnt_reg != {SCNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule
